// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Consumers select FWFT read mode at compile time with SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefDepth    = 16;
    localparam int unsigned DefAfThresh = DefDepth - 2;
    localparam int unsigned DefAeThresh = 2;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Address bits only; the pointers carry one extra wrap bit on top of this.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
// Contents are never reset; validity is tracked by the FIFO pointers.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill level, almost flags, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered dout.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = DefAeThresh,
    localparam int unsigned PTR_WIDTH = ptr_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   din,
    input  logic               rd_en,
    input  logic               flush,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [PTR_WIDTH:0] count,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned CntW = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               wr_accept, rd_accept;
    logic [WIDTH-1:0]   ram_rdata;

    // Status is a function of the registered pointers only.
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                          (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= CntW'(AF_THRESH));
    assign almost_empty = (count <= CntW'(AE_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_accept = wr_en && !full && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_accept) wptr_d = wptr_q + CntW'(1);
            if (rd_accept) rptr_d = rptr_q + CntW'(1);
        end
        // A fresh error in the same cycle as err_clr wins.
        overflow_d  = (overflow_q && !err_clr) || (wr_en && full);
        underflow_d = (underflow_q && !err_clr) || (rd_en && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_accept),
        .waddr_i (wptr_q[PTR_WIDTH-1:0]),
        .wdata_i (din),
        .raddr_i (rptr_q[PTR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; forced to zero while empty.
    assign dout = empty ? '0 : ram_rdata;
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    assign dout_d = rd_accept ? ram_rdata : dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at default parameters.
// Works in both read modes; SYNC_FIFO_FWFT_EN selects the FWFT expectations.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       flush;
    logic       err_clr;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb_q[$];
    int         m_count = 0;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;
    logic [7:0] m_dout  = 8'h00;

    sync_fifo_param dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .flush        (flush),
        .err_clr      (err_clr),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        check("count", 32'(count), 32'(m_count));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("full", 32'(full), 32'(m_count == 16));
        check("almost_full", 32'(almost_full), 32'(m_count >= 14));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (m_count != 0) check("fwft_dout", 32'(dout), 32'(sb_q[0]));
`else
        check("dout", 32'(dout), 32'(m_dout));
`endif
    endtask

    // One clock of stimulus, then update the model and compare.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic ec);
        logic acc_w, acc_r;
        acc_w = wr && (m_count != 16) && !fl;
        acc_r = rd && (m_count != 0) && !fl;
        wr_en = wr; din = d; rd_en = rd; flush = fl; err_clr = ec;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        m_ovf = (m_ovf && !ec) || (wr && m_count == 16);
        m_unf = (m_unf && !ec) || (rd && m_count == 0);
        if (fl) begin
            m_count = 0;
            sb_q.delete();
        end else begin
            if (acc_r) begin
                m_dout = sb_q.pop_front();
                m_count--;
            end
            if (acc_w) begin
                sb_q.push_back(d);
                m_count++;
            end
        end
        check_state();
    endtask

    task automatic model_reset();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout  = 8'h00;
        sb_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; din = 8'h00; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        #12;
        check_state();
        check("rst_dout", 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset with five entries stored.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h35, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        check("rst_mid_dout", 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, one overflow write, then drain in order.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Underflow on empty read, then clear both error flags.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Simultaneous read/write at count 8 across pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);

        // Flush with a concurrent write at count 10.
        step(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b1, 1'b0);

        // Flush must leave a set overflow flag alone.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Mode check: single 0xA5 through an empty FIFO.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        check("mode_dout", 32'(dout), 32'hA5);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO with a programmable fill level, almost-full/almost-empty thresholds, a synchronous flush and sticky overflow/underflow error flags. It is the single-domain successor to the dual-clock FIFO and replaces it wherever producer and consumer share one clock, so no pointer synchronisers are needed. An optional first-word-fall-through (FWFT) read mode is selected at compile time.

## Interface
- WIDTH, 8: data width in bits.
- DEPTH, 16: number of entries; power of two, minimum 4.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.
- PTR_WIDTH: localparam, clog2(DEPTH); not overridable.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low. All state is cleared on assertion; release is synchronous to clk.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read request.
- flush  in  1  synchronous clear of contents.
- err_clr  in  1  clears overflow and underflow.
- dout  out  WIDTH  read data.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- count  out  PTR_WIDTH+1  current fill level, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Pointers: wptr and rptr are binary, PTR_WIDTH+1 bits each. The low PTR_WIDTH bits address the RAM. The MSB is a wrap bit.
- empty = (wptr == rptr).
- full = (MSBs differ) and (low bits equal).
- count = wptr - rptr, computed modulo 2^(PTR_WIDTH+1).
- A write is accepted iff wr_en && !full. It stores din at wptr[PTR_WIDTH-1:0] and increments wptr.
- A read is accepted iff rd_en && !empty. It increments rptr.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- When full, wr_en is dropped even if a read is accepted in the same cycle. overflow is set.
- When empty, rd_en is dropped even if a write is accepted in the same cycle. underflow is set.
- flush has priority over wr_en and rd_en. It sets wptr = rptr = 0. RAM contents are not cleared.
- err_clr clears overflow and underflow. If a new error occurs in the same cycle, set wins.
- flush does not affect the error flags.
- Wrap-around: pointers roll over from 2^(PTR_WIDTH+1)-1 to 0. No special handling is needed.
- almost_full and almost_empty are pure compares on count. Both may be high together if the thresholds overlap; this is legal.

## Timing
- Reset values: dout=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- All flags and count derive combinationally from registered pointers only. They update in the cycle after the accepting edge. There is no combinational path from wr_en or rd_en to any output.
- Write-to-not-empty latency: 1 clk.
- Non-FWFT read: dout is registered. It updates 1 clk after the accepted read edge and holds otherwise. flush does not change dout.
- FWFT read: dout = RAM[rptr] combinationally whenever !empty, so first data is visible 1 clk after the write. rd_en acknowledges and pops that word. dout is don't-care while empty.
- Reset asserted mid-operation: state clears immediately. Stored data is discarded logically.

## Configuration
- SYNC_FIFO_FWFT_EN defined: FWFT read mode as above. The registered dout stage is removed.
- SYNC_FIFO_FWFT_EN undefined: standard mode with 1-cycle registered dout.
- Flag, count and error behaviour is identical in both modes.

## Structure
- Package sync_fifo_pkg holds:
  - the clog2 function;
  - default WIDTH, DEPTH and threshold constants;
  - the pointer-width computation.
- One sub-module, sync_fifo_ram: DEPTH x WIDTH dual-port RAM with synchronous write and asynchronous read.
- Pointer, flag and error logic stays in the top level.

## Test plan
All scenarios use default parameters (WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2).
- Reset: assert rst_n=0 mid-stream with count=5 -> all outputs at their reset values immediately; count=0, empty=1.
- Fill: write 0x00..0x0F with no reads -> almost_full rises after the 14th write, full after the 16th. A 17th write sets overflow, count stays 16, and draining returns 0x00..0x0F.
- Underflow: rd_en on an empty FIFO -> underflow=1, count=0, pointers unchanged. err_clr for 1 clk -> underflow=0.
- Simultaneous: with count=8, assert wr_en and rd_en for 20 cycles -> count holds 8, data stays in order across pointer wrap, no error flags.
- Flush: with count=10, flush plus wr_en in the same cycle -> next cycle count=0, empty=1, write discarded, error flags unchanged.
- Mode check: run with and without SYNC_FIFO_FWFT_EN -> write 0xA5 to an empty FIFO. FWFT: dout=0xA5 1 clk after the write, before any rd_en. Standard: dout=0xA5 1 clk after rd_en.
